rs_alu: RTL and testbench

- Reservation station for the ALU functional unit.
- Sits directly downstream of dispatch: accepts renamed ALU instructions on dispatch_alu_en / dispatch_alu_instr and reports rs_alu_full back to dispatch.
- Holds instructions until both physical source operands are ready (woken by the CDB broadcast), then issues one ready instruction per cycle to the ALU / register-read stage.

---
 rtl/rs_alu.sv | 154 +++++++++++++++
 tb/tb_rs_alu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu.sv
// ALU reservation station: holds renamed instructions until both sources are
// ready, then issues the lowest-index ready entry once per cycle.

package rs_alu_pkg;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic [ROB_W-1:0]  rob_tag;
    } renamed_instr_t;
endpackage

module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE   = 8,
    parameter int PREG_BITS = PREG_W,
    parameter int CNT_BITS  = $clog2(RS_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 dispatch_alu_en,
    input  renamed_instr_t       dispatch_alu_instr,
    input  logic                 src1_ready_in,
    input  logic                 src2_ready_in,
    output logic                 rs_alu_full,
    input  logic                 cdb_valid,
    input  logic [PREG_BITS-1:0] cdb_tag,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output renamed_instr_t       issue_instr,
    output logic [CNT_BITS-1:0]  occupancy
);

    localparam int IDX_BITS = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]  valid_r;
    logic [RS_SIZE-1:0]  rdy1_r;
    logic [RS_SIZE-1:0]  rdy2_r;
    renamed_instr_t      instr_r [RS_SIZE];
    logic [CNT_BITS-1:0] occ_r;

    logic [RS_SIZE-1:0]  cand_s;
    logic [RS_SIZE-1:0]  free_s;
    logic [RS_SIZE-1:0]  wake1_s;
    logic [RS_SIZE-1:0]  wake2_s;
    logic [IDX_BITS-1:0] sel_idx_s;
    logic [IDX_BITS-1:0] free_idx_s;
    logic                full_s;
    logic                any_cand_s;
    logic                alloc_s;
    logic                fire_s;
    logic                bypass1_s;
    logic                bypass2_s;
    logic [CNT_BITS-1:0] alloc_inc_s;
    logic [CNT_BITS-1:0] fire_dec_s;

    // Candidates use registered readiness only, so a wakeup counts one cycle later.
    always_comb begin
        cand_s     = valid_r & rdy1_r & rdy2_r;
        free_s     = ~valid_r;
        full_s     = (occ_r == CNT_BITS'(RS_SIZE));
        any_cand_s = |cand_s;
    end

    // Lowest-index priority encoders: scanning downward lets the lowest hit win.
    always_comb begin
        sel_idx_s  = {IDX_BITS{1'b0}};
        free_idx_s = {IDX_BITS{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            sel_idx_s  = cand_s[i] ? IDX_BITS'(i) : sel_idx_s;
            free_idx_s = free_s[i] ? IDX_BITS'(i) : free_idx_s;
        end
    end

    // CDB tag match against every resident entry's sources.
    always_comb begin
        wake1_s = {RS_SIZE{1'b0}};
        wake2_s = {RS_SIZE{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            wake1_s[i] = valid_r[i] && cdb_valid && (cdb_tag == instr_r[i].prs1);
            wake2_s[i] = valid_r[i] && cdb_valid && (cdb_tag == instr_r[i].prs2);
        end
    end

    // Dispatch-time readiness, including a broadcast landing in the same cycle.
    always_comb begin
        bypass1_s = src1_ready_in
                    || (dispatch_alu_instr.prs1 == {PREG_BITS{1'b0}})
                    || (cdb_valid && (cdb_tag == dispatch_alu_instr.prs1));
        bypass2_s = src2_ready_in
                    || (dispatch_alu_instr.prs2 == {PREG_BITS{1'b0}})
                    || (cdb_valid && (cdb_tag == dispatch_alu_instr.prs2));
    end

    // Handshake qualification; a flush discards both allocation and issue.
    always_comb begin
        alloc_s     = dispatch_alu_en && !full_s && !flush;
        fire_s      = any_cand_s && issue_ready && !flush;
        alloc_inc_s = {{(CNT_BITS-1){1'b0}}, alloc_s};
        fire_dec_s  = {{(CNT_BITS-1){1'b0}}, fire_s};
    end

    // Outputs are pure functions of the entry state.
    always_comb begin
        rs_alu_full = full_s;
        issue_valid = any_cand_s;
        occupancy   = occ_r;
        if (any_cand_s) begin
            issue_instr = instr_r[sel_idx_s];
        end else begin
            issue_instr = '0;
        end
    end

    // Entry state; the allocated slot was free at cycle start so it never aliases the issuing one.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_r <= {RS_SIZE{1'b0}};
            rdy1_r  <= {RS_SIZE{1'b0}};
            rdy2_r  <= {RS_SIZE{1'b0}};
            occ_r   <= {CNT_BITS{1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                instr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (alloc_s && (free_idx_s == IDX_BITS'(i))) begin
                    valid_r[i] <= 1'b1;
                    instr_r[i] <= dispatch_alu_instr;
                    rdy1_r[i]  <= bypass1_s;
                    rdy2_r[i]  <= bypass2_s;
                end else begin
                    if (fire_s && (sel_idx_s == IDX_BITS'(i))) begin
                        valid_r[i] <= 1'b0;
                    end
                    if (wake1_s[i]) begin
                        rdy1_r[i] <= 1'b1;
                    end
                    if (wake2_s[i]) begin
                        rdy2_r[i] <= 1'b1;
                    end
                end
            end
            occ_r <= occ_r + alloc_inc_s - fire_dec_s;
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: expected issues are queued by the stimulus and
// consumed by a monitor on each accepted issue handshake.

module tb_rs_alu;
    import rs_alu_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           dispatch_alu_en;
    renamed_instr_t dispatch_alu_instr;
    logic           src1_ready_in;
    logic           src2_ready_in;
    logic           rs_alu_full;
    logic           cdb_valid;
    logic [5:0]     cdb_tag;
    logic           issue_valid;
    logic           issue_ready;
    renamed_instr_t issue_instr;
    logic [3:0]     occupancy;

    int n_checks   = 0;
    int n_fails    = 0;
    int proto_viol = 0;
    renamed_instr_t exp_q[$];

    rs_alu dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .dispatch_alu_en    (dispatch_alu_en),
        .dispatch_alu_instr (dispatch_alu_instr),
        .src1_ready_in      (src1_ready_in),
        .src2_ready_in      (src2_ready_in),
        .rs_alu_full        (rs_alu_full),
        .cdb_valid          (cdb_valid),
        .cdb_tag            (cdb_tag),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_instr        (issue_instr),
        .occupancy          (occupancy)
    );

    always #5 clk = ~clk;

    function automatic renamed_instr_t mk(input logic [5:0] p1, input logic [5:0] p2,
                                          input logic [4:0] rob);
        renamed_instr_t r;
        r.opcode  = rob[3:0];
        r.prd     = {1'b1, rob};
        r.prs1    = p1;
        r.prs2    = p2;
        r.rob_tag = rob;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input renamed_instr_t ins, input logic r1, input logic r2);
        dispatch_alu_en    = 1'b1;
        dispatch_alu_instr = ins;
        src1_ready_in      = r1;
        src2_ready_in      = r2;
        cycle();
        dispatch_alu_en = 1'b0;
        src1_ready_in   = 1'b0;
        src2_ready_in   = 1'b0;
    endtask

    task automatic bcast(input logic [5:0] tag);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cycle();
        cdb_valid = 1'b0;
    endtask

    // Dispatching into a full station is a protocol error on the dispatch side.
    always @(posedge clk) begin
        if (!rst) begin
            a_no_dispatch_when_full: assert (!(dispatch_alu_en && rs_alu_full))
                else proto_viol++;
        end
    end

    // Scoreboard monitor: every accepted issue must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && !flush && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_issue: got rob_tag %0d expected no issue", issue_instr.rob_tag);
            end else begin
                chk("issue_instr", 32'(issue_instr), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; dispatch_alu_en = 1'b0; dispatch_alu_instr = '0;
        src1_ready_in = 1'b0; src2_ready_in = 1'b0; cdb_valid = 1'b0; cdb_tag = 6'd0;
        issue_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        chk("reset_full", 32'(rs_alu_full), 32'd0);
        chk("reset_issue_valid", 32'(issue_valid), 32'd0);
        chk("reset_issue_instr", 32'(issue_instr), 32'd0);

        // Ready instruction issues the cycle after dispatch.
        exp_q.push_back(mk(6'd3, 6'd0, 5'd1));
        disp(mk(6'd3, 6'd0, 5'd1), 1'b1, 1'b1);
        chk("ready_issue_valid", 32'(issue_valid), 32'd1);
        chk("ready_issue_instr", 32'(issue_instr), 32'(mk(6'd3, 6'd0, 5'd1)));
        chk("ready_occupancy", 32'(occupancy), 32'd1);
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        chk("ready_drain_occupancy", 32'(occupancy), 32'd0);
        chk("ready_drain_issue_valid", 32'(issue_valid), 32'd0);

        // CDB wakeup, eligible only the cycle after the broadcast.
        disp(mk(6'd5, 6'd0, 5'd2), 1'b0, 1'b0);
        chk("wait_issue_valid_a", 32'(issue_valid), 32'd0);
        cycle();
        chk("wait_issue_valid_b", 32'(issue_valid), 32'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd5;
        chk("wake_same_cycle_issue_valid", 32'(issue_valid), 32'd0);
        cycle();
        cdb_valid = 1'b0;
        chk("wake_issue_valid", 32'(issue_valid), 32'd1);
        chk("wake_issue_instr", 32'(issue_instr), 32'(mk(6'd5, 6'd0, 5'd2)));
        exp_q.push_back(mk(6'd5, 6'd0, 5'd2));
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        chk("wake_drain_occupancy", 32'(occupancy), 32'd0);

        // Broadcast in the dispatch cycle bypasses into both sources.
        cdb_valid = 1'b1;
        cdb_tag   = 6'd5;
        disp(mk(6'd5, 6'd5, 5'd3), 1'b0, 1'b0);
        cdb_valid = 1'b0;
        chk("bypass_issue_valid", 32'(issue_valid), 32'd1);
        exp_q.push_back(mk(6'd5, 6'd5, 5'd3));
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        chk("bypass_drain_occupancy", 32'(occupancy), 32'd0);

        // Fill all eight slots with waiting instructions (prs2 = 0 is always ready).
        for (int i = 0; i < 8; i++) begin
            disp(mk(6'(10 + i), 6'd0, 5'(8 + i)), 1'b0, 1'b0);
        end
        chk("fill_full", 32'(rs_alu_full), 32'd1);
        chk("fill_occupancy", 32'(occupancy), 32'd8);
        chk("fill_issue_valid", 32'(issue_valid), 32'd0);
        disp(mk(6'd30, 6'd0, 5'd20), 1'b1, 1'b1);
        chk("full_dispatch_flagged", 32'(proto_viol), 32'd1);
        chk("full_dispatch_occupancy", 32'(occupancy), 32'd8);
        chk("full_dispatch_issue_valid", 32'(issue_valid), 32'd0);

        // Free slot 3, then refill it.
        bcast(6'd13);
        chk("slot3_issue_instr", 32'(issue_instr), 32'(mk(6'd13, 6'd0, 5'd11)));
        exp_q.push_back(mk(6'd13, 6'd0, 5'd11));
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        chk("freed_full", 32'(rs_alu_full), 32'd0);
        chk("freed_occupancy", 32'(occupancy), 32'd7);
        disp(mk(6'd14, 6'd0, 5'd21), 1'b0, 1'b0);
        chk("refill_full", 32'(rs_alu_full), 32'd1);

        // Tag 14 wakes the refilled slot 3 and slot 4; slot 3 must go first.
        bcast(6'd14);
        exp_q.push_back(mk(6'd14, 6'd0, 5'd21));
        issue_ready = 1'b1;
        cycle();
        chk("pre_simul_occupancy", 32'(occupancy), 32'd7);
        exp_q.push_back(mk(6'd14, 6'd0, 5'd12));
        disp(mk(6'd15, 6'd0, 5'd22), 1'b0, 1'b0);
        issue_ready = 1'b0;
        chk("simul_occupancy", 32'(occupancy), 32'd7);
        chk("simul_full", 32'(rs_alu_full), 32'd0);
        chk("simul_issue_valid", 32'(issue_valid), 32'd0);

        // New entry took slot 3, so it precedes slot 5 on the shared tag.
        bcast(6'd15);
        chk("simul_slot_order", 32'(issue_instr), 32'(mk(6'd15, 6'd0, 5'd22)));
        exp_q.push_back(mk(6'd15, 6'd0, 5'd22));
        exp_q.push_back(mk(6'd15, 6'd0, 5'd13));
        issue_ready = 1'b1;
        cycle();
        cycle();
        issue_ready = 1'b0;
        chk("five_left_occupancy", 32'(occupancy), 32'd5);

        // Flush with a live issue handshake and a dispatch in the same cycle.
        bcast(6'd10);
        chk("preflush_issue_valid", 32'(issue_valid), 32'd1);
        flush              = 1'b1;
        issue_ready        = 1'b1;
        dispatch_alu_en    = 1'b1;
        dispatch_alu_instr = mk(6'd40, 6'd0, 5'd23);
        src1_ready_in      = 1'b1;
        src2_ready_in      = 1'b1;
        cycle();
        flush = 1'b0; issue_ready = 1'b0; dispatch_alu_en = 1'b0;
        src1_ready_in = 1'b0; src2_ready_in = 1'b0;
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        chk("flush_issue_valid", 32'(issue_valid), 32'd0);
        chk("flush_full", 32'(rs_alu_full), 32'd0);
        cycle();
        chk("post_flush_occupancy", 32'(occupancy), 32'd0);
        chk("post_flush_issue_valid", 32'(issue_valid), 32'd0);

        // Backpressure: slots 1 and 2 ready, slot 0 waiting.
        disp(mk(6'd50, 6'd0, 5'd24), 1'b0, 1'b0);
        disp(mk(6'd51, 6'd0, 5'd25), 1'b1, 1'b1);
        disp(mk(6'd52, 6'd0, 5'd26), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("stall_issue_valid", 32'(issue_valid), 32'd1);
            chk("stall_issue_instr", 32'(issue_instr), 32'(mk(6'd51, 6'd0, 5'd25)));
            cycle();
        end
        exp_q.push_back(mk(6'd51, 6'd0, 5'd25));
        exp_q.push_back(mk(6'd52, 6'd0, 5'd26));
        issue_ready = 1'b1;
        cycle();
        chk("second_issue_instr", 32'(issue_instr), 32'(mk(6'd52, 6'd0, 5'd26)));
        cycle();
        issue_ready = 1'b0;
        chk("stall_drain_occupancy", 32'(occupancy), 32'd1);
        chk("stall_drain_issue_valid", 32'(issue_valid), 32'd0);
        bcast(6'd50);
        exp_q.push_back(mk(6'd50, 6'd0, 5'd24));
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        chk("slot0_drain_occupancy", 32'(occupancy), 32'd0);

        // Reset mid-operation overrides a simultaneous dispatch and issue.
        disp(mk(6'd60, 6'd0, 5'd27), 1'b1, 1'b1);
        chk("pre_rst_occupancy", 32'(occupancy), 32'd1);
        rst                = 1'b1;
        issue_ready        = 1'b1;
        dispatch_alu_en    = 1'b1;
        dispatch_alu_instr = mk(6'd61, 6'd0, 5'd28);
        src1_ready_in      = 1'b1;
        src2_ready_in      = 1'b1;
        cycle();
        rst = 1'b0; issue_ready = 1'b0; dispatch_alu_en = 1'b0;
        src1_ready_in = 1'b0; src2_ready_in = 1'b0;
        chk("midrst_occupancy", 32'(occupancy), 32'd0);
        chk("midrst_issue_valid", 32'(issue_valid), 32'd0);
        cycle();
        chk("post_midrst_issue_valid", 32'(issue_valid), 32'd0);

        chk("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
